// File: rtl/jk_excitation_driver_if.sv
// Bundles the word-source handshake, latch-bank drive/feedback and write-status
// signals of jk_excitation_driver. The driver connects through the slave modport.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             lat_en;
  logic             done;
  logic             err;
  logic [7:0]       err_cnt;

  modport master (
    output in_valid,
    output in_data,
    output q_fb,
    input  in_ready,
    input  j,
    input  k,
    input  lat_en,
    input  done,
    input  err,
    input  err_cnt
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  q_fb,
    output in_ready,
    output j,
    output k,
    output lat_en,
    output done,
    output err,
    output err_cnt
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Write controller for a bank of JK latches: excite, strobe, settle, read back.
// Define JK_EXCITE_TOGGLE_PREF_EN to resolve excitation don't-cares to 1 (toggle form).
module jk_excitation_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jk_excitation_driver_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_target;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_lat_en;
  logic             r_done;
  logic             r_err;
  logic [7:0]       r_err_cnt;

  logic             w_accept;
  logic             w_leave_check;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_j_exc;
  logic [WIDTH-1:0] w_k_exc;

  // in_ready is registered, so the first IDLE cycle after reset cannot accept.
  assign w_accept      = (r_state == ST_IDLE) && bus.in_valid && r_in_ready;
  assign w_leave_check = (r_state == ST_CHECK);
  assign w_mismatch    = (bus.q_fb != r_target);

`ifdef JK_EXCITE_TOGGLE_PREF_EN
  assign w_j_exc = bus.q_fb | bus.in_data;
  assign w_k_exc = ~(bus.q_fb & bus.in_data);
`else
  assign w_j_exc = ~bus.q_fb & bus.in_data;
  assign w_k_exc = bus.q_fb & ~bus.in_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_DRIVE;
      ST_DRIVE:  w_next_state = ST_SETTLE;
      ST_SETTLE: if (r_cnt == 4'd0) w_next_state = ST_CHECK;
      ST_CHECK:  w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (r_state == ST_DRIVE) begin
      r_cnt <= SETTLE_LOAD;
    end else if ((r_state == ST_SETTLE) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
    end else if (w_accept) begin
      r_target <= bus.in_data;
    end
  end

  // Excitation is loaded only on accept, so J/K read as hold outside DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_lat_en   <= 1'b0;
      r_j        <= '0;
      r_k        <= '0;
    end else begin
      r_in_ready <= (w_next_state == ST_IDLE);
      r_lat_en   <= w_accept;
      r_j        <= w_accept ? w_j_exc : '0;
      r_k        <= w_accept ? w_k_exc : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_done <= w_leave_check;
      r_err  <= w_leave_check && w_mismatch;
      if (w_leave_check && w_mismatch && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.j        = r_j;
  assign bus.k        = r_k;
  assign bus.lat_en   = r_lat_en;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_cnt  = r_err_cnt;

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Sequential driver that writes target words into an external bank of JK latches. For each accepted target word it reads the bank's current state and computes per-bit J/K inputs from the JK excitation table. It then strobes the bank for one cycle, waits a programmable settle time and reads the bank back to confirm the write. It sits between a valid/ready word source and a WIDTH-bit array of `jk_latch` instances, acting as their write controller.

## Interface
- `WIDTH`, 8: bits per word and number of latches driven.
- `SETTLE`, 2: idle cycles between strobe and readback; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: source presents `in_data`.
- `in_ready` out 1: driver can accept a word.
- `in_data` in WIDTH: target word.
- `q_fb` in WIDTH: current Q outputs of the latch bank.
- `j`, `k` out WIDTH each: J/K inputs to the latch bank.
- `lat_en` out 1: one-cycle clock/enable strobe to the latch bank.
- `done` out 1: one-cycle pulse when a write completes.
- `err` out 1: readback mismatch; valid only while `done`=1.
- `err_cnt` out 8: saturating count of mismatched writes.

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: register `in_data` as `target`, register `q_fb` as `cur`, compute J/K, go to DRIVE.
- **DRIVE**
  - `lat_en`=1 for exactly this cycle; `j`/`k` hold the computed values.
  - Next state: SETTLE; counter loaded with SETTLE-1.
- **SETTLE**
  - `j`=`k`=0 (hold) and `lat_en`=0.
  - Counter decrements; go to CHECK when it reaches 0.
- **CHECK**
  - Compare `q_fb` against `target`.
  - On the leaving edge: `done`<=1, `err`<=(`q_fb`!=`target`), and `err_cnt`+=`err` (saturates at 255, no wrap).
  - Next state: IDLE.
- **Excitation, macro off** (don't-care resolved to 0): `j`=~`cur`&`target`, `k`=`cur`&~`target`. Hold bits get J=K=0.
- **Excitation, macro on**: see Configuration.
- `in_data` is ignored outside IDLE. `in_valid` may stay high across busy cycles; the word is taken on the first IDLE cycle.
- `err_cnt` is cleared only by reset.

## Timing
- **Registered outputs; reset values:** `in_ready`=0, `j`=0, `k`=0, `lat_en`=0, `done`=0, `err`=0, `err_cnt`=0. FSM resets to IDLE.
- **After reset release:** `in_ready` rises on the first rising edge.
- **Accept edge E0:** enters DRIVE, so `lat_en`/`j`/`k` are valid during cycle E0..E1.
- **`done` and `err`:** asserted for exactly one cycle, from edge E(SETTLE+2). With SETTLE=2 that is edge E4.
- **`in_ready`:** rises on the same edge as `done`. The earliest next accept is E(SETTLE+3), so sustained throughput is one word per SETTLE+3 cycles.
- **`q_fb` sampling:** at the accept edge (for `cur`) and at the edge leaving CHECK (for the readback). Between those edges `q_fb` may change freely.
- **Reset mid-operation:** the asynchronous assertion immediately zeroes all outputs. No `done` is produced for the aborted word, and the latch bank keeps whatever state it reached.
- **Degenerate case:** if `target`==`cur`, the strobe is still issued, with J=K=0 when the macro is off.

## Configuration
- Macro `JK_EXCITE_TOGGLE_PREF_EN`.
- **Defined:** don't-cares resolve to 1, giving `j`=`cur`|`target` and `k`=~(`cur`&`target`).
  - Transitions 0→1 and 1→0 use toggle (J=K=1).
  - Hold-at-0 uses J=0,K=1; hold-at-1 uses J=1,K=0.
- **Undefined:** don't-cares resolve to 0, using the minimal set/reset/hold encoding given under Operation.
- FSM, timing and the readback check are identical in both builds.

## Test plan
All scenarios use WIDTH=8 and SETTLE=2.
- **Basic write (macro off):** bank model at 0x00, write 0xA5.
  - `j`=0xA5, `k`=0x00 during DRIVE only; `lat_en` high for 1 cycle.
  - `done` at E4 with `err`=0, and bank reads 0xA5.
- **Encoding comparison:** bank at 0xF0, write 0x3C.
  - Macro off: `j`=0x0C, `k`=0xC0.
  - Macro on: `j`=0xFC, `k`=0xCF.
  - In both builds the bank ends at 0x3C and `err`=0.
- **Readback mismatch:** bank model stuck at 0x00, write 0xFF.
  - `done`=1 with `err`=1; `err_cnt`=1.
  - After 300 such writes, `err_cnt`=255 and does not wrap.
- **Backpressure:** `in_valid` held high with words 0x11 then 0x22.
  - `in_ready`=0 through DRIVE/SETTLE/CHECK.
  - Second accept occurs 5 cycles after the first; `done` pulses are 5 cycles apart.
- **Reset mid-SETTLE:** assert `rst_n`=0 during the SETTLE state.
  - All outputs drop to 0 asynchronously, with no `done` pulse and `err_cnt`=0.
  - After release, `in_ready`=1 on the first edge and a new write completes normally.
